// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by both the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int UART_CLKS_PER_BIT_12M_115200 = 104;
   localparam int UART_DATA_BITS               = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with combinational read port; only instantiated when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, rdPtr_q;
   logic             wrEn, rdEn;

   // A push into a full FIFO is only allowed when the same cycle frees a slot.
   assign wrEn = push && (!full || pop);
   assign rdEn = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
         if (rdEn) rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) mem_q[wrPtr_q[AW-1:0]] <= push_data;
   end

   assign pop_data = mem_q[rdPtr_q[AW-1:0]];
   assign empty    = (wrPtr_q == rdPtr_q);
   assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered tx pin.
// Define UART_TX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO and send frames back to back.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_12M_115200,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
      $error("uart_tx: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH a power of two >= 2");
   end

   uart_state_t               state_q, state_d;
   logic [CNT_W-1:0]          clkCnt_q, clkCnt_d;
   logic [IDX_W-1:0]          bitIdx_q, bitIdx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      tx_q, tx_d;
   logic                      accept, pending, loadByte, bitEnd;
   logic [UART_DATA_BITS-1:0] loadData;

   assign accept = in_valid && in_ready;
   assign bitEnd = (clkCnt_q == CNT_LAST);

`ifdef UART_TX_FIFO_EN
   logic fifoFull, fifoEmpty;

   uart_tx_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (in_data),
      .pop       (loadByte),
      .pop_data  (loadData),
      .full      (fifoFull),
      .empty     (fifoEmpty)
   );

   assign in_ready = !fifoFull && !rst;
   assign pending  = !fifoEmpty;
   assign busy     = ((state_q != IDLE) || pending) && !rst;
`else
   assign in_ready = (state_q == IDLE) && !rst;
   assign pending  = accept;
   assign loadData = in_data;
   assign busy     = (state_q != IDLE) && !rst;
`endif

   // A new byte is taken either from idle or at the very end of a stop bit.
   assign loadByte = pending && ((state_q == IDLE) || ((state_q == STOP) && bitEnd));

   // Next-state logic; tx_d is the line level for the cycle after this edge.
   always_comb begin
      state_d  = state_q;
      clkCnt_d = clkCnt_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
      case (state_q)
         IDLE: begin
            if (loadByte) begin
               state_d  = START;
               clkCnt_d = '0;
               shift_d  = loadData;
               tx_d     = 1'b0;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bitEnd) begin
               state_d  = DATA;
               clkCnt_d = '0;
               bitIdx_d = '0;
               tx_d     = shift_q[0];
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (bitEnd) begin
               clkCnt_d = '0;
               shift_d  = shift_q >> 1;
               if (bitIdx_q == IDX_LAST) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
                  tx_d     = shift_q[1];
               end
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bitEnd) begin
               clkCnt_d = '0;
               if (loadByte) begin
                  state_d = START;
                  shift_d = loadData;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               clkCnt_d = clkCnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            clkCnt_d = '0;
            bitIdx_d = '0;
            tx_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         clkCnt_q <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         clkCnt_q <= clkCnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at CLKS_PER_BIT=4; covers FIFO or no-FIFO build per UART_TX_FIFO_EN.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_FIFO_EN
   localparam int START_LAT = 1;
`else
   localparam int START_LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, tx, busy;
   int         total = 0;
   int         bad = 0;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [39:0] expand(input logic [9:0] bits);
      logic [39:0] r;
      for (int k = 0; k < 40; k++) r[k] = bits[k/CPB];
      return r;
   endfunction

   function automatic logic [39:0] frameOf(input logic [7:0] b);
      return expand({1'b1, b, 1'b0});
   endfunction

   function automatic logic [7:0] decode(input logic [39:0] seq);
      logic [7:0] d;
      for (int k = 0; k < 8; k++) d[k] = seq[CPB*(k+1) + 2];
      return d;
   endfunction

   // Present a byte, wait for the handshake, and leave in_valid low at the next negedge.
   task automatic applyStimulus(input logic [7:0] b, output bit ok);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (in_ready === 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitStart(output int lat, output bit ok);
      lat = 0;
      while (tx !== 1'b0 && lat < 4) begin
         @(negedge clk);
         lat++;
      end
      ok = (tx === 1'b0);
   endtask

   task automatic captureFrame(output logic [39:0] seq, output int busyLow);
      busyLow = 0;
      for (int i = 0; i < 40; i++) begin
         seq[i] = tx;
         if (busy !== 1'b1) busyLow++;
         @(negedge clk);
      end
   endtask

   // Send one byte and return the observed 40-cycle frame; handshake/start timeouts count as failures.
   task automatic sendCapture(input logic [7:0] b, input string name, output logic [39:0] seq,
                              output int lat, output int busyLow);
      bit ok;
      applyStimulus(b, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s_accept: got in_ready=0 expected handshake within 200 cycles", name);
      end
      waitStart(lat, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s_start: got tx=%b expected start bit within 4 cycles", name, tx);
      end
      captureFrame(seq, busyLow);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (tx !== 1'b1) begin bad++; $display("[TB] FAIL rst_tx: got %b expected 1", tx); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b expected 0", in_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_idle();
      int txLow, busyHigh, readyLow;
      txLow = 0; busyHigh = 0; readyLow = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx !== 1'b1) txLow++;
         if (busy !== 1'b0) busyHigh++;
         if (in_ready !== 1'b1) readyLow++;
         @(negedge clk);
      end
      total++;
      if (txLow != 0) begin bad++; $display("[TB] FAIL idle_tx: got %0d low cycles expected 0", txLow); end
      total++;
      if (busyHigh != 0) begin bad++; $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busyHigh); end
      total++;
      if (readyLow != 0) begin bad++; $display("[TB] FAIL idle_ready: got %0d not-ready cycles expected 0", readyLow); end
   endtask

   task automatic test_single_a5();
      logic [39:0] seq;
      int lat, busyLow;
      sendCapture(8'hA5, "a5", seq, lat, busyLow);
      total++;
      if (lat != START_LAT) begin bad++; $display("[TB] FAIL a5_latency: got %0d expected %0d", lat, START_LAT); end
      total++;
      if (seq !== expand(10'b1101001010)) begin
         bad++;
         $display("[TB] FAIL a5_frame: got %h expected %h", seq, expand(10'b1101001010));
      end
      total++;
      if (busyLow != 0) begin bad++; $display("[TB] FAIL a5_busy_frame: got %0d idle cycles expected 0", busyLow); end
      total++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         bad++;
         $display("[TB] FAIL a5_after: got busy=%b tx=%b expected busy=0 tx=1", busy, tx);
      end
   endtask

   task automatic test_loopback();
      logic [7:0]  bytes [4];
      logic [39:0] seq;
      int lat, busyLow, validCount;
      logic [7:0] d;
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'h3C;
      validCount = 0;
      for (int n = 0; n < 4; n++) begin
         sendCapture(bytes[n], "loop", seq, lat, busyLow);
         d = decode(seq);
         if (seq[2] === 1'b0 && seq[38] === 1'b1) validCount++;
         total++;
         if (d !== bytes[n]) begin
            bad++;
            $display("[TB] FAIL loop_data%0d: got %h expected %h", n, d, bytes[n]);
         end
      end
      total++;
      if (validCount != 4) begin bad++; $display("[TB] FAIL loop_valid: got %0d expected 4", validCount); end
   endtask

   task automatic test_reset_midframe();
      logic [39:0] seq;
      int lat, busyLow, glitches;
      bit ok;
      applyStimulus(8'h0F, ok);
      waitStart(lat, ok);
      total++;
      if (!ok) begin bad++; $display("[TB] FAIL midrst_start: got tx=%b expected 0", tx); end
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (tx !== 1'b1) begin bad++; $display("[TB] FAIL midrst_tx: got %b expected 1", tx); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      rst = 1'b0;
      glitches = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) glitches++;
      end
      total++;
      if (glitches != 0) begin bad++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", glitches); end
      sendCapture(8'h81, "post_rst", seq, lat, busyLow);
      total++;
      if (seq !== frameOf(8'h81)) begin
         bad++;
         $display("[TB] FAIL post_rst_frame: got %h expected %h", seq, frameOf(8'h81));
      end
   endtask

`ifdef UART_TX_FIFO_EN
   task automatic test_fifo_burst();
      logic [759:0] txLog;
      logic [39:0]  seq;
      int cnt, firstLowAt, idleBad;
      bit acceptNow;
      cnt = 0; firstLowAt = -1; idleBad = 0;
      in_data  = 8'h00;
      in_valid = 1'b1;
      for (int i = 0; i < 760; i++) begin
         txLog[i] = tx;
         if (in_ready !== 1'b1 && firstLowAt < 0) firstLowAt = cnt;
         acceptNow = in_valid && (in_ready === 1'b1);
         @(negedge clk);
         if (acceptNow) begin
            cnt++;
            if (cnt == 17) in_valid = 1'b0;
            else in_data = 8'(cnt);
         end
      end
      total++;
      if (cnt != 17) begin bad++; $display("[TB] FAIL fifo_accepts: got %0d expected 17", cnt); end
      total++;
      if (firstLowAt != 17) begin bad++; $display("[TB] FAIL fifo_ready_drop: got %0d expected 17", firstLowAt); end
      total++;
      if (txLog[1:0] !== 2'b11) begin bad++; $display("[TB] FAIL fifo_lead: got %b expected 11", txLog[1:0]); end
      for (int f = 0; f < 17; f++) begin
         for (int k = 0; k < 40; k++) seq[k] = txLog[2 + 40*f + k];
         total++;
         if (seq !== frameOf(8'(f))) begin
            bad++;
            $display("[TB] FAIL fifo_frame%0d: got %h expected %h", f, seq, frameOf(8'(f)));
         end
      end
      for (int i = 682; i < 760; i++) if (txLog[i] !== 1'b1) idleBad++;
      total++;
      if (idleBad != 0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL fifo_tail: got %0d low cycles busy=%b expected 0 busy=0", idleBad, busy);
      end
   endtask
`else
   task automatic test_back_to_back();
      logic [39:0] seq1, seq2;
      int n, readyHigh, busyLow;
      n = 0; readyHigh = 0;
      in_data  = 8'h12;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept: got in_ready=0 expected 1"); end
      @(negedge clk);
      in_data = 8'h34;
      for (int i = 0; i < 40; i++) begin
         seq1[i] = tx;
         if (in_ready !== 1'b0) readyHigh++;
         @(negedge clk);
      end
      total++;
      if (readyHigh != 0) begin bad++; $display("[TB] FAIL b2b_ready_low: got %0d ready cycles expected 0", readyHigh); end
      total++;
      if (tx !== 1'b1 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_gap: got tx=%b ready=%b expected tx=1 ready=1", tx, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      captureFrame(seq2, busyLow);
      total++;
      if (seq1 !== frameOf(8'h12)) begin bad++; $display("[TB] FAIL b2b_frame1: got %h expected %h", seq1, frameOf(8'h12)); end
      total++;
      if (seq2 !== frameOf(8'h34)) begin bad++; $display("[TB] FAIL b2b_frame2: got %h expected %h", seq2, frameOf(8'h34)); end
      total++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_after: got busy=%b tx=%b expected busy=0 tx=1", busy, tx);
      end
   endtask
`endif

   initial begin
      $display("[TB] uart_tx bench start");
      test_reset();
      test_idle();
      test_single_a5();
      test_loopback();
      test_reset_midframe();
`ifdef UART_TX_FIFO_EN
      test_fifo_burst();
`else
      test_back_to_back();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
